// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Hazard controller for the five-stage pipeline. It covers the hazards that
//   EX-stage forwarding cannot resolve:
//   - load-use stalls
//   - taken-branch flushes
//   - sequencing of the multi-cycle MULT/DIV unit, including HI/LO interlocks
//   It also keeps a saturating stall-cycle counter for performance
//   measurement.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_id_rs/i_id_rt  source registers of the ID instruction
//   i_id_use_rt      ID instruction reads rt
//   i_id_hilo_rd     ID instruction is MFHI/MFLO
//   i_id_md          ID instruction is MULT/MULTU/DIV/DIVU
//   i_ex_mem_rd      EX instruction is a load
//   i_ex_rt          destination register of the load in EX
//   i_ex_md          MULT/DIV instruction in EX
//   i_ex_md_div      1 = the EX MULT/DIV instruction is a divide
//   i_ex_br_taken    branch/jump in EX resolved taken
//   o_pc_wr          PC load enable
//   o_ifid_wr        IF/ID load enable
//   o_ifid_flush     clear IF/ID to a nop
//   o_idex_flush     bubble into ID/EX
//   o_md_start       one-cycle start pulse to the MULT/DIV unit
//   o_md_busy        MULT/DIV operation in flight
//   o_hilo_wr        one-cycle HI/LO write strobe
//   o_stall_cnt      saturating stall-cycle count
//
// States:
//   ST_IDLE | no MULT/DIV in flight; an EX MULT/DIV starts one here
//   ST_BUSY | r_cnt counts down to the HI/LO write cycle (r_cnt == 0)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_use_rt,
    input  logic        i_id_hilo_rd,
    input  logic        i_id_md,
    input  logic        i_ex_mem_rd,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_ex_md,
    input  logic        i_ex_md_div,
    input  logic        i_ex_br_taken,
    output logic        o_pc_wr,
    output logic        o_ifid_wr,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_md_start,
    output logic        o_md_busy,
    output logic        o_hilo_wr,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic        w_lu_haz;
    logic        w_md_haz;
    logic        w_stall_evt;
    logic        w_md_start;
    logic        w_md_busy;
    logic        w_hilo_wr;

    assign w_lu_haz = i_ex_mem_rd && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == i_id_rs) || (i_id_use_rt && (i_ex_rt == i_id_rt)));

    // The HI/LO write cycle itself is not a hazard: the reader enters EX one
    // cycle later, after HI/LO has been updated.
    assign w_md_haz = (i_id_hilo_rd || i_id_md) &&
                      (((r_state == ST_IDLE) && i_ex_md) ||
                       ((r_state == ST_BUSY) && (r_cnt != 8'd0)));

    // A taken branch discards the ID instruction, so its stall is not counted.
    assign w_stall_evt = i_rst_n && !i_ex_br_taken && (w_lu_haz || w_md_haz);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The in-flight MULT/DIV is older than any branch in EX, so flushes never
    // touch this sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_start  = 1'b0;
        w_md_busy   = 1'b0;
        w_hilo_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ex_md) begin
                    w_md_start  = 1'b1;
                    w_md_busy   = 1'b1;
                    w_cnt_nxt   = i_ex_md_div ? DIV_LOAD : MUL_LOAD;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_md_busy = 1'b1;
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_hilo_wr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_pc_wr      = 1'b1;
        o_ifid_wr    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_md_start   = w_md_start;
        o_md_busy    = w_md_busy;
        o_hilo_wr    = w_hilo_wr;
        if (i_ex_br_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_lu_haz || w_md_haz) begin
            o_pc_wr      = 1'b0;
            o_ifid_wr    = 1'b0;
            o_idex_flush = 1'b1;
        end
        // Reset is asynchronous, and the EX inputs may still be live while it
        // is asserted, so the outputs are forced directly.
        if (!i_rst_n) begin
            o_pc_wr      = 1'b1;
            o_ifid_wr    = 1'b1;
            o_ifid_flush = 1'b0;
            o_idex_flush = 1'b0;
            o_md_start   = 1'b0;
            o_md_busy    = 1'b0;
            o_hilo_wr    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rt, id_hilo_rd, id_md;
    logic        ex_mem_rd, ex_md, ex_md_div, ex_br_taken;
    logic        pc_wr, ifid_wr, ifid_flush, idex_flush;
    logic        md_start, md_busy, hilo_wr;
    logic [15:0] stall_cnt;

    // Output vector order: {pc_wr, ifid_wr, ifid_flush, idex_flush, md_start, md_busy, hilo_wr}
    logic [6:0]  exp_q[$];
    logic [6:0]  obs;
    logic [6:0]  e;
    logic [15:0] obs_cnt;
    logic [15:0] sb_stall;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_use_rt   (id_use_rt),
        .i_id_hilo_rd  (id_hilo_rd),
        .i_id_md       (id_md),
        .i_ex_mem_rd   (ex_mem_rd),
        .i_ex_rt       (ex_rt),
        .i_ex_md       (ex_md),
        .i_ex_md_div   (ex_md_div),
        .i_ex_br_taken (ex_br_taken),
        .o_pc_wr       (pc_wr),
        .o_ifid_wr     (ifid_wr),
        .o_ifid_flush  (ifid_flush),
        .o_idex_flush  (idex_flush),
        .o_md_start    (md_start),
        .o_md_busy     (md_busy),
        .o_hilo_wr     (hilo_wr),
        .o_stall_cnt   (stall_cnt)
    );

    // Inputs are driven at posedge+1; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        obs     = {pc_wr, ifid_wr, ifid_flush, idex_flush, md_start, md_busy, hilo_wr};
        obs_cnt = stall_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rt = 1'b0; id_hilo_rd = 1'b0; id_md = 1'b0;
        ex_mem_rd = 1'b0; ex_md = 1'b0; ex_md_div = 1'b0; ex_br_taken = 1'b0;
    endtask

    // Expected outputs from the hazard priority: branch > stall > normal.
    task automatic push_exp(input bit br, input bit stall, input bit start,
                            input bit busy, input bit hilo);
        logic run;
        run = !br && !stall;
        exp_q.push_back({br || run, br || run, br, br || stall, start, busy, hilo});
        if (!br && stall && sb_stall != 16'hFFFF) sb_stall = sb_stall + 16'd1;
    endtask

    task automatic push_rst();
        exp_q.push_back(7'b1100000);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        sb_stall = 16'd0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        ex_md = 1'b1; ex_mem_rd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_hilo_rd = 1'b1;
        sb_stall = 16'd0;
        push_rst();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, e); end
        checks++;
        if (obs_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", obs_cnt); end
        set_idle();
        rst_n = 1'b1;
        push_exp(0, 0, 0, 0, 0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release got %b want %b", obs, e); end
    endtask

    task automatic test_load_use();
        do_reset();
        // {ex_mem_rd, ex_rt, id_rs, id_rt, use_rt, stall}
        for (int k = 0; k < 8; k++) begin
            set_idle();
            case (k)
                0: begin ex_mem_rd = 1; ex_rt = 8; id_rs = 8; end
                1: begin ex_mem_rd = 0; ex_rt = 8; id_rs = 8; end
                2: begin ex_mem_rd = 1; ex_rt = 0; id_rs = 0; end
                3: begin ex_mem_rd = 1; ex_rt = 8; id_rs = 3; id_rt = 8; id_use_rt = 1; end
                4: begin ex_mem_rd = 1; ex_rt = 8; id_rs = 3; id_rt = 8; id_use_rt = 0; end
                5: begin ex_mem_rd = 1; ex_rt = 0; id_rs = 3; id_rt = 0; id_use_rt = 1; end
                6: begin ex_mem_rd = 1; ex_rt = 31; id_rs = 31; end
                default: begin ex_mem_rd = 1; ex_rt = 9; id_rs = 8; id_rt = 8; id_use_rt = 1; end
            endcase
            push_exp(0, (k == 0) || (k == 3) || (k == 6), 0, 0, 0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL load_use case%0d got %b want %b", k, obs, e); end
        end
        set_idle();
        tick();
        checks++;
        if (obs_cnt !== sb_stall) begin errors++; $display("FAIL load_use_cnt got %0d want %0d", obs_cnt, sb_stall); end
    endtask

    task automatic test_mult_mfhi();
        do_reset();
        for (int k = 0; k <= MUL_LAT + 1; k++) begin
            set_idle();
            ex_md = (k == 0);
            id_hilo_rd = (k <= MUL_LAT);
            push_exp(0, k < MUL_LAT, k == 0, k <= MUL_LAT, k == MUL_LAT);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL mult_mfhi cyc%0d got %b want %b", k, obs, e); end
        end
        set_idle();
        tick();
        checks++;
        if (obs_cnt !== sb_stall || sb_stall !== 16'(MUL_LAT)) begin
            errors++; $display("FAIL mult_mfhi_cnt got %0d want %0d", obs_cnt, MUL_LAT);
        end
    endtask

    task automatic test_div();
        int busy_cyc;
        int hilo_at;
        busy_cyc = 0;
        hilo_at = -1;
        do_reset();
        for (int k = 0; k <= DIV_LAT + 2; k++) begin
            set_idle();
            ex_md = (k == 0);
            ex_md_div = 1'b1;
            push_exp(0, 0, k == 0, k <= DIV_LAT, k == DIV_LAT);
            tick();
            e = exp_q.pop_front();
            if (obs[1]) busy_cyc++;
            if (obs[0]) hilo_at = k;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL div cyc%0d got %b want %b", k, obs, e); end
        end
        checks++;
        if (busy_cyc != DIV_LAT + 1) begin errors++; $display("FAIL div_busy_len got %0d want %0d", busy_cyc, DIV_LAT + 1); end
        checks++;
        if (hilo_at != DIV_LAT) begin errors++; $display("FAIL div_hilo_at got %0d want %0d", hilo_at, DIV_LAT); end
    endtask

    task automatic test_branch();
        do_reset();
        set_idle();
        ex_mem_rd = 1; ex_rt = 8; id_rs = 8; ex_br_taken = 1;
        push_exp(1, 1, 0, 0, 0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL branch_over_lu got %b want %b", obs, e); end
        for (int k = 0; k <= MUL_LAT + 1; k++) begin
            set_idle();
            ex_md = (k == 0);
            ex_br_taken = (k == 2);
            id_md = (k == 2);
            push_exp(k == 2, (k == 2) && (k < MUL_LAT), k == 0, k <= MUL_LAT, k == MUL_LAT);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch_busy cyc%0d got %b want %b", k, obs, e); end
        end
        set_idle();
        tick();
        checks++;
        if (obs_cnt !== 16'd0) begin errors++; $display("FAIL branch_cnt got %0d want 0", obs_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k <= 2 * MUL_LAT + 2; k++) begin
            set_idle();
            ex_md = (k == 0) || (k == MUL_LAT + 1);
            id_md = (k <= MUL_LAT);
            push_exp(0, (k <= MUL_LAT) && (k < MUL_LAT),
                     (k == 0) || (k == MUL_LAT + 1),
                     k <= 2 * MUL_LAT + 1,
                     (k == MUL_LAT) || (k == 2 * MUL_LAT + 1));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back cyc%0d got %b want %b", k, obs, e); end
        end
        set_idle();
        tick();
        checks++;
        if (obs_cnt !== sb_stall) begin errors++; $display("FAIL back_to_back_cnt got %0d want %0d", obs_cnt, sb_stall); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_idle();
            ex_md = (k == 0); ex_md_div = 1'b1; id_hilo_rd = 1'b1;
            push_exp(0, 1, k == 0, 1, 0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL midop_pre cyc%0d got %b want %b", k, obs, e); end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || hilo_wr !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL midop_async got busy=%b hilo=%b cnt=%0d want 0 0 0", md_busy, hilo_wr, stall_cnt);
        end
        sb_stall = 16'd0;
        for (int k = 0; k < 3; k++) begin
            push_rst();
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL midop_held cyc%0d got %b want %b", k, obs, e); end
        end
        set_idle();
        rst_n = 1'b1;
        for (int k = 0; k < DIV_LAT + 4; k++) begin
            push_exp(0, 0, 0, 0, 0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL midop_after cyc%0d got %b want %b", k, obs, e); end
        end
        checks++;
        if (obs_cnt !== 16'd0) begin errors++; $display("FAIL midop_cnt got %0d want 0", obs_cnt); end
        for (int k = 0; k <= MUL_LAT + 1; k++) begin
            set_idle();
            ex_md = (k == 0);
            push_exp(0, 0, k == 0, k <= MUL_LAT, k == MUL_LAT);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL midop_newmult cyc%0d got %b want %b", k, obs, e); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_idle();
        ex_mem_rd = 1; ex_rt = 5'd12; id_rs = 5'd12;
        repeat (65534) tick();
        tick();
        checks++;
        if (obs_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", obs_cnt); end
        tick();
        checks++;
        if (obs_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h want ffff", obs_cnt); end
        repeat (5) tick();
        checks++;
        if (obs_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", obs_cnt); end
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        sb_stall = 16'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mult_mfhi();
        test_div();
        test_branch();
        test_back_to_back();
        test_reset_mid_op();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
